// File: rtl/digit_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_pkg
// Brief    : Shared state encoding, default parameters and elaboration helpers
//            for the digit_entry keypad number-entry block.
// Revision : 1.0 - initial release
// ============================================================================
package digit_entry_pkg;

   localparam int c_NDIGITS_DEF = 4;
   localparam int c_BASE_DEF    = 10;
   localparam int c_VW_DEF      = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EDIT = 2'd1,
      S_FULL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Integer power, used only at elaboration to prove value cannot overflow.
   function automatic longint unsigned pow_u64(input int unsigned b, input int unsigned e);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < e; i++) begin
         r = r * longint'(b);
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_entry_key_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_edge
// Brief    : Two-flop synchroniser and falling-edge pulse for one active-low key.
// Revision : 1.0 - initial release
// ============================================================================
module key_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // All flops reset to the pressed level so a key held through reset is silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_fall = r_prev & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry
// Brief    : Keypad-driven multi-digit number entry with backspace, clear and
//            a valid/ready handoff of the finished value.
// Revision : 1.0 - initial release
// ============================================================================
module digit_entry
   import digit_entry_pkg::*;
#(
   parameter int NDIGITS = c_NDIGITS_DEF,
   parameter int BASE    = c_BASE_DEF,
   parameter int VW      = c_VW_DEF
) (
   input  logic                             on3,
   input  logic                             rst_n,
   input  logic                             KEY_DIGIT,
   input  logic                             KEY_INCREMENT,
   input  logic                             KEY_DELETE,
   input  logic                             KEY_ENTER,
   input  logic                             switch,
   input  logic                             out_ready,
   output logic [VW-1:0]                    value,
   output logic                             out_valid,
   output logic [3:0]                       cur_digit,
   output logic                             digit_blank,
   output logic [$clog2(NDIGITS+1)-1:0]     count,
   output logic                             Led
);

   localparam int            CW         = $clog2(NDIGITS+1);
   localparam logic [VW-1:0] c_BASE_V   = VW'(BASE);
   localparam logic [3:0]    c_DIG_MAX  = 4'(BASE - 1);
   localparam logic [CW-1:0] c_FULL_CNT = CW'(NDIGITS);
   localparam bit            c_FITS     = (VW >= 64) ||
                                          (pow_u64(BASE, NDIGITS) <= (64'd1 << VW));

   if (BASE < 2 || BASE > 16) begin : g_bad_base
      $error("digit_entry: BASE must be within 2..16");
   end
   if (!c_FITS) begin : g_bad_width
      $error("digit_entry: VW too narrow for BASE**NDIGITS-1");
   end

   // Key index: 0 digit, 1 increment, 2 delete, 3 enter.
   logic [3:0] w_keys_n;
   logic [3:0] w_fall;
   assign w_keys_n = {KEY_ENTER, KEY_DELETE, KEY_INCREMENT, KEY_DIGIT};

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_edge u_key_edge (
         .clk     (on3),
         .rst_n   (rst_n),
         .i_key_n (w_keys_n[i]),
         .o_fall  (w_fall[i])
      );
   end

   state_t        r_state, w_state_nx;
   logic [VW-1:0] r_value, w_value_nx;
   logic [CW-1:0] r_count, w_count_nx;
   logic [3:0]    r_digit, w_digit_nx;
   logic [VW-1:0] w_commit_value;
   logic [CW-1:0] w_count_inc;
   logic          w_commit_full;

   always_ff @(posedge on3 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_value <= '0;
         r_count <= '0;
         r_digit <= '0;
      end else begin
         r_state <= w_state_nx;
         r_value <= w_value_nx;
         r_count <= w_count_nx;
         r_digit <= w_digit_nx;
      end
   end

   assign w_commit_value = (r_value * c_BASE_V) + VW'(r_digit);
   assign w_count_inc    = r_count + CW'(1);
   assign w_commit_full  = (w_count_inc == c_FULL_CNT);

   always_comb begin
      w_state_nx = r_state;
      w_value_nx = r_value;
      w_count_nx = r_count;
      w_digit_nx = r_digit;
      if (switch) begin
         w_state_nx = S_IDLE;
         w_value_nx = '0;
         w_count_nx = '0;
         w_digit_nx = '0;
      end else if (r_state == S_DONE) begin
         if (out_ready) begin
            w_state_nx = S_IDLE;
            w_value_nx = '0;
            w_count_nx = '0;
         end
      end else if (w_fall[2]) begin
         if (r_state == S_EDIT) begin
            w_state_nx = S_IDLE;
            w_digit_nx = '0;
         end else if (r_count != '0) begin
            w_state_nx = S_IDLE;
            w_value_nx = r_value / c_BASE_V;
            w_count_nx = r_count - CW'(1);
         end
      end else if (w_fall[3]) begin
         w_state_nx = S_DONE;
         if (r_state == S_EDIT) begin
            w_value_nx = w_commit_value;
            w_count_nx = w_count_inc;
            w_digit_nx = '0;
         end
      end else if (w_fall[1]) begin
         if (r_state == S_EDIT) begin
            w_state_nx = w_commit_full ? S_FULL : S_IDLE;
            w_value_nx = w_commit_value;
            w_count_nx = w_count_inc;
            w_digit_nx = '0;
         end
      end else if (w_fall[0]) begin
         if (r_state == S_IDLE) begin
            w_state_nx = S_EDIT;
            w_digit_nx = '0;
         end else if (r_state == S_EDIT) begin
            w_digit_nx = (r_digit == c_DIG_MAX) ? 4'd0 : r_digit + 4'd1;
         end
      end
   end

   assign value       = r_value;
   assign out_valid   = (r_state == S_DONE);
   assign cur_digit   = r_digit;
   assign digit_blank = (r_state != S_EDIT);
   assign count       = r_count;
   assign Led         = (r_count == c_FULL_CNT);

endmodule
`default_nettype wire

// File: tb/tb_digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_entry
// Brief    : Directed self-checking bench for digit_entry (NDIGITS=4, BASE=10, VW=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_entry;

   logic        on3 = 1'b0;
   logic        rst_n;
   logic        key_digit, key_inc, key_del, key_ent;
   logic        sw, out_ready;
   logic [15:0] value;
   logic        out_valid;
   logic [3:0]  cur_digit;
   logic        digit_blank;
   logic [2:0]  count;
   logic        led;

   int n_checks = 0;
   int n_fail   = 0;

   digit_entry #(.NDIGITS(4), .BASE(10), .VW(16)) dut (
      .on3           (on3),
      .rst_n         (rst_n),
      .KEY_DIGIT     (key_digit),
      .KEY_INCREMENT (key_inc),
      .KEY_DELETE    (key_del),
      .KEY_ENTER     (key_ent),
      .switch        (sw),
      .out_ready     (out_ready),
      .value         (value),
      .out_valid     (out_valid),
      .cur_digit     (cur_digit),
      .digit_blank   (digit_blank),
      .count         (count),
      .Led           (led)
   );

   always #5 on3 = ~on3;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mask bits: 0 digit, 1 increment, 2 delete, 3 enter
   task automatic press(input logic [3:0] m, input int hold);
      @(negedge on3);
      key_digit = ~m[0];
      key_inc   = ~m[1];
      key_del   = ~m[2];
      key_ent   = ~m[3];
      repeat (hold) @(negedge on3);
      key_digit = 1'b1;
      key_inc   = 1'b1;
      key_del   = 1'b1;
      key_ent   = 1'b1;
      repeat (4) @(negedge on3);
   endtask

   task automatic press_n(input logic [3:0] m, input int n);
      for (int i = 0; i < n; i++) press(m, 1);
   endtask

   task automatic clear_switch();
      @(negedge on3);
      sw = 1'b1;
      @(negedge on3);
      sw = 1'b0;
   endtask

   task automatic handshake();
      @(negedge on3);
      out_ready = 1'b1;
      @(negedge on3);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      key_digit = 1'b1; key_inc = 1'b1; key_del = 1'b1; key_ent = 1'b1;
      sw = 1'b0; out_ready = 1'b0;
      #1;
      check("rst_value", value, 0);
      check("rst_valid", out_valid, 0);
      check("rst_cur", cur_digit, 0);
      check("rst_blank", digit_blank, 1);
      check("rst_count", count, 0);
      check("rst_led", led, 0);
      repeat (3) @(negedge on3);
      rst_n = 1'b1;
      repeat (4) @(negedge on3);

      // Digit wrap and hold-length independence
      press_n(4'b0001, 11);
      check("wrap_cur", cur_digit, 0);
      check("wrap_blank", digit_blank, 0);
      press(4'b0001, 20);
      check("hold_cur", cur_digit, 1);
      clear_switch();
      check("sw_blank", digit_blank, 1);
      check("sw_cur", cur_digit, 0);

      // Enter 1, 2, 3 and finish
      press_n(4'b0001, 2);
      press(4'b0010, 1);
      check("c1_value", value, 1);
      press_n(4'b0001, 3);
      press(4'b0010, 1);
      check("c2_value", value, 12);
      press_n(4'b0001, 4);
      press(4'b1000, 1);
      check("ent_valid", out_valid, 1);
      check("ent_value", value, 123);
      check("ent_count", count, 3);

      // Value held while consumer stalls; keys ignored in DONE
      for (int i = 0; i < 5; i++) begin
         @(negedge on3);
         check("stall_value", value, 123);
         check("stall_valid", out_valid, 1);
      end
      press(4'b0101, 1);
      check("done_ign_value", value, 123);
      check("done_ign_blank", digit_blank, 1);
      handshake();
      check("hs_valid", out_valid, 0);
      check("hs_value", value, 0);
      check("hs_count", count, 0);

      // Backspace behaviour
      press_n(4'b0001, 2); press(4'b0010, 1);
      press_n(4'b0001, 3); press(4'b0010, 1);
      press_n(4'b0001, 4); press(4'b0010, 1);
      check("b_value", value, 123);
      press(4'b0100, 1);
      check("del_value", value, 12);
      check("del_count", count, 2);
      press_n(4'b0001, 6);
      check("del_cur", cur_digit, 5);
      press(4'b0100, 1);
      check("del_edit_blank", digit_blank, 1);
      check("del_edit_value", value, 12);
      check("del_edit_count", count, 2);
      press_n(4'b0100, 2);
      check("del_zero_value", value, 0);
      press(4'b0100, 1);
      check("del_empty_count", count, 0);
      press(4'b1000, 1);
      check("empty_ent_valid", out_valid, 1);
      check("empty_ent_value", value, 0);
      handshake();
      check("hs2_valid", out_valid, 0);

      // Fill to capacity
      for (int d = 0; d < 4; d++) begin
         press_n(4'b0001, 10);
         press(4'b0010, 1);
      end
      check("full_value", value, 9999);
      check("full_led", led, 1);
      check("full_count", count, 4);
      press(4'b0010, 1);
      press(4'b0001, 1);
      check("full_ign_value", value, 9999);
      check("full_ign_blank", digit_blank, 1);
      press(4'b0100, 1);
      check("full_del_value", value, 999);
      check("full_del_led", led, 0);

      // Same-cycle priority
      press(4'b0101, 1);
      check("pri_del_value", value, 99);
      check("pri_del_blank", digit_blank, 1);
      press(4'b0001, 1);
      press(4'b0011, 1);
      check("pri_inc_value", value, 990);
      check("pri_inc_count", count, 3);
      press(4'b1010, 1);
      check("pri_ent_valid", out_valid, 1);
      check("pri_ent_value", value, 990);
      clear_switch();
      check("sw_done_valid", out_valid, 0);
      check("sw_done_value", value, 0);

      // Reset mid-entry with a key held through release
      press_n(4'b0001, 2); press(4'b0010, 1);
      press(4'b0001, 1);
      check("pre_rst_blank", digit_blank, 0);
      @(negedge on3);
      key_digit = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_value", value, 0);
      check("arst_blank", digit_blank, 1);
      check("arst_count", count, 0);
      repeat (2) @(negedge on3);
      rst_n = 1'b1;
      repeat (5) @(negedge on3);
      key_digit = 1'b1;
      repeat (4) @(negedge on3);
      check("held_no_event", digit_blank, 1);
      press(4'b0001, 1);
      check("post_rst_blank", digit_blank, 0);
      check("post_rst_cur", cur_digit, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, maximum committed digits.
REQ-002 SHALL have parameter BASE, default 10, digit radix, 2..16.
REQ-003 SHALL have parameter VW, default 32, width of value.
REQ-004 SHALL have port on3  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port KEY_DIGIT  in  1  active-low, steps pending digit.
REQ-007 SHALL have port KEY_INCREMENT  in  1  active-low, commits pending digit.
REQ-008 SHALL have port KEY_DELETE  in  1  active-low, backspace.
REQ-009 SHALL have port KEY_ENTER  in  1  active-low, finishes entry.
REQ-010 SHALL have port switch  in  1  level, high clears entry.
REQ-011 SHALL have port out_ready  in  1  consumer accepts value.
REQ-012 SHALL have port value  out  VW  accumulated number, unsigned.
REQ-013 SHALL have port out_valid  out  1  value final, held for handshake.
REQ-014 SHALL have port cur_digit  out  4  pending digit, for display.
REQ-015 SHALL have port digit_blank  out  1  no pending digit.
REQ-016 SHALL have port count  out  $clog2(NDIGITS+1)  committed digits.
REQ-017 SHALL have port Led  out  1  high while count == NDIGITS.

Function
REQ-018 Each key SHALL pass a 2-flop synchroniser plus falling-edge detector; one press SHALL be one event regardless of hold time.
REQ-019 A key first sampled low at edge N SHALL take effect on outputs after edge N+2.
REQ-020 Same-cycle priority SHALL be switch > KEY_DELETE > KEY_ENTER > KEY_INCREMENT > KEY_DIGIT; lower events SHALL be dropped.
REQ-021 FSM states SHALL be IDLE (blank, count<NDIGITS), EDIT (digit pending), FULL (count==NDIGITS), DONE (out_valid high).
REQ-022 KEY_DIGIT in IDLE SHALL set cur_digit 0, clear digit_blank, go EDIT; in EDIT it SHALL increment, wrapping BASE-1 to 0.
REQ-023 KEY_INCREMENT in EDIT SHALL set value = value*BASE + cur_digit, count+1, set blank, go IDLE or FULL; it SHALL be ignored in IDLE and FULL.
REQ-024 KEY_DIGIT SHALL be ignored in FULL.
REQ-025 KEY_DELETE in EDIT SHALL blank the pending digit; in IDLE/FULL with count>0 SHALL set value = value/BASE, count-1, go IDLE; with count 0 it SHALL be ignored.
REQ-026 KEY_ENTER in EDIT SHALL commit the pending digit as REQ-023, then go DONE; in IDLE/FULL it SHALL go DONE with value unchanged (0 if nothing entered).
REQ-027 In DONE out_valid SHALL be 1, value stable, all keys ignored.
REQ-028 On out_valid & out_ready at an edge, the FSM SHALL go IDLE with value 0, count 0, out_valid 0 after that edge.
REQ-029 switch high SHALL, each cycle, force IDLE, value 0, count 0, digit_blank 1, cur_digit 0, out_valid 0.
REQ-030 Elaboration SHALL fail if BASE**NDIGITS-1 exceeds 2**VW-1, so value never overflows.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, value 0, out_valid 0, cur_digit 0, digit_blank 1, count 0, Led 0.
REQ-032 Synchroniser and edge-history flops SHALL reset to the pressed (low) level, so a key held across reset release produces no event.
REQ-033 Reset mid-entry SHALL discard partial value; no event SHALL be lost or duplicated after release apart from REQ-032.

Structure
REQ-034 Package digit_entry_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-035 Sub-module key_edge (synchroniser plus falling-edge pulse) SHALL be instantiated once per key.

Verification (NDIGITS=4, BASE=10, VW=16)
REQ-036 DIGIT x2, INCREMENT, DIGIT x3, INCREMENT, DIGIT x4, ENTER -> out_valid 1, value 123, count 3.
REQ-037 DIGIT x11 from IDLE -> cur_digit 0, digit_blank 0; one press held 20 cycles -> one step only.
REQ-038 Four commits of 9 -> value 9999, Led 1; fifth INCREMENT and DIGIT -> no change.
REQ-039 After 123 committed: DELETE -> value 12, count 2; DIGIT x6 then DELETE -> digit_blank 1, value 12.
REQ-040 DONE with out_ready low 5 cycles -> value 123, out_valid held; out_ready high -> next cycle out_valid 0, value 0.
REQ-041 rst_n low in EDIT with KEY_DIGIT held through release -> outputs reset at once, no digit event after release.
